// File: rtl/counter_stream_checker.sv
// Receive-side checker for the counter host stream: rebuilds the expected count from
// observed enable/count history and reports sticky count and period-pulse errors.
//
// state    | meaning
// UNLOCKED | re-anchor on the observed count, clear run counters
// ACQUIRE  | counting consecutive good samples toward lock, no flags raised
// TRACK    | locked; bad samples and pulse-interval errors are flagged
module counter_stream_checker #(
    parameter int COUNT_WIDTH = 12,
    parameter int PERIOD      = 100,
    parameter int LOCK_LEN    = 4,
    parameter int MAX_MISS    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] count_in,
    input  logic                   pulse_in,
    input  logic                   clear_err,
    output logic                   locked,
    output logic                   mismatch,
    output logic [15:0]            mismatch_count,
    output logic [COUNT_WIDTH-1:0] syndrome,
    output logic                   period_err,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        TRACK    = 2'd2
    } state_t;

    localparam int GOOD_W = $clog2(LOCK_LEN + 1);
    localparam int MISS_W = $clog2(MAX_MISS + 1);
    localparam int INT_W  = $clog2(2 * PERIOD + 2);

    localparam logic [GOOD_W-1:0] LOCK_TC   = GOOD_W'(LOCK_LEN);
    localparam logic [MISS_W-1:0] MISS_TC   = MISS_W'(MAX_MISS);
    localparam logic [INT_W-1:0]  PERIOD_TC = INT_W'(PERIOD);
    localparam logic [INT_W-1:0]  SAT_TC    = INT_W'(2 * PERIOD);

    state_t                  st;
    logic                    en_d1;
    logic                    en_d2;
    logic [COUNT_WIDTH-1:0]  prev;
    logic [GOOD_W-1:0]       good_run;
    logic [MISS_W-1:0]       miss_run;
    logic [INT_W-1:0]        int_cnt;
    logic                    armed;

    logic [COUNT_WIDTH-1:0]  exp_cnt;
    logic                    sample_good;
    logic [GOOD_W-1:0]       good_inc;
    logic [MISS_W-1:0]       miss_inc;
    logic [INT_W-1:0]        int_inc;
    logic                    bad_track;
    logic                    perr_set;

    assign exp_cnt     = prev + {{(COUNT_WIDTH-1){1'b0}}, en_d2};
    assign sample_good = (count_in == exp_cnt);
    assign good_inc    = good_run + GOOD_W'(1);
    assign miss_inc    = miss_run + MISS_W'(1);
    assign int_inc     = int_cnt + INT_W'(1);
    assign bad_track   = (st == TRACK) && !sample_good;

    // Period error: wrong interval at a pulse, or the first time the interval saturates.
    assign perr_set = (st == TRACK) && en_d1 && armed &&
                      ((pulse_in && (int_inc != PERIOD_TC)) ||
                       (!pulse_in && (int_inc == SAT_TC) && (int_cnt != SAT_TC)));

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= UNLOCKED;
            locked         <= 1'b0;
            en_d1          <= 1'b0;
            en_d2          <= 1'b0;
            prev           <= '0;
            good_run       <= '0;
            miss_run       <= '0;
            int_cnt        <= '0;
            armed          <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            syndrome       <= '0;
            period_err     <= 1'b0;
        end else begin
            en_d1 <= enable;
            en_d2 <= en_d1;
            prev  <= count_in;

            case (st)
                UNLOCKED: begin
                    good_run <= '0;
                    miss_run <= '0;
                    armed    <= 1'b0;
                    int_cnt  <= '0;
                    st       <= ACQUIRE;
                end
                ACQUIRE: begin
                    if (sample_good) begin
                        if (good_inc == LOCK_TC) begin
                            st       <= TRACK;
                            locked   <= 1'b1;
                            miss_run <= '0;
                            armed    <= 1'b0;
                            int_cnt  <= '0;
                        end else begin
                            good_run <= good_inc;
                        end
                    end else begin
                        good_run <= '0;
                    end
                end
                TRACK: begin
                    if (!sample_good) begin
                        if (miss_inc == MISS_TC) begin
                            st     <= UNLOCKED;
                            locked <= 1'b0;
                        end else begin
                            miss_run <= miss_inc;
                        end
                    end else begin
                        miss_run <= '0;
                    end
                    // The first pulse after lock only arms the interval check.
                    if (en_d1) begin
                        if (pulse_in) begin
                            armed   <= 1'b1;
                            int_cnt <= '0;
                        end else if (armed && (int_cnt != SAT_TC)) begin
                            int_cnt <= int_inc;
                        end
                    end
                end
                default: begin
                    st     <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase

            if (clear_err) begin
                mismatch       <= 1'b0;
                mismatch_count <= '0;
                syndrome       <= '0;
                period_err     <= 1'b0;
            end else begin
                if (bad_track) begin
                    mismatch <= 1'b1;
                    if (mismatch_count != 16'hFFFF)
                        mismatch_count <= mismatch_count + 16'd1;
                    if (!mismatch)
                        syndrome <= count_in ^ exp_cnt;
                end
                if (perr_set)
                    period_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_stream_checker.sv
// Bench for counter_stream_checker: a behavioural host model drives the stream and a
// queue of expected output snapshots is compared after each step of interest.
module tb_counter_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] count_in = '0;
    logic        pulse_in = 1'b0;
    logic        clear_err = 1'b0;
    logic        locked;
    logic        mismatch;
    logic [15:0] mismatch_count;
    logic [11:0] syndrome;
    logic        period_err;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] host_cnt = '0;
    logic        host_en_d1 = 1'b0;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        mm;
        logic [15:0] mc;
        logic [11:0] syn;
        logic        syn_en;
        logic        pe;
    } exp_t;

    exp_t sb[$];

    counter_stream_checker #(
        .COUNT_WIDTH(12), .PERIOD(100), .LOCK_LEN(4), .MAX_MISS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .count_in(count_in),
        .pulse_in(pulse_in), .clear_err(clear_err), .locked(locked),
        .mismatch(mismatch), .mismatch_count(mismatch_count), .syndrome(syndrome),
        .period_err(period_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic mm,
                              input logic [15:0] mc, input logic [11:0] syn,
                              input logic syn_en, input logic pe);
        exp_t e;
        e.tag = tag; e.st = st; e.mm = mm; e.mc = mc;
        e.syn = syn; e.syn_en = syn_en; e.pe = pe;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".state"}, 32'(state), 32'(e.st));
            chk({e.tag, ".locked"}, 32'(locked), 32'(e.st == 2'd2));
            chk({e.tag, ".mismatch"}, 32'(mismatch), 32'(e.mm));
            chk({e.tag, ".mismatch_count"}, 32'(mismatch_count), 32'(e.mc));
            if (e.syn_en)
                chk({e.tag, ".syndrome"}, 32'(syndrome), 32'(e.syn));
            chk({e.tag, ".period_err"}, 32'(period_err), 32'(e.pe));
        end
    endtask

    // One clock of stimulus; host model: count(t+1) = count(t) + enable(t-1).
    task automatic cyc(input logic en, input logic [11:0] xm, input logic [11:0] addv,
                       input logic pl);
        enable   = en;
        count_in = (host_cnt ^ xm) + addv;
        pulse_in = pl;
        @(posedge clk);
        #1;
        host_cnt   = host_cnt + {11'b0, host_en_d1};
        host_en_d1 = en;
    endtask

    task automatic run_clean(input int n, input logic en);
        for (int i = 0; i < n; i++) cyc(en, 12'h000, 12'h000, 1'b0);
    endtask

    task automatic clear_cycle(input string tag);
        clear_err = 1'b1;
        expect_out(tag, 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        cyc(1'b1, 12'h000, 12'h000, 1'b0);
        check_out();
        clear_err = 1'b0;
    endtask

    initial begin
        // Async reset with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        expect_out("reset", 2'd0, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        check_out();

        repeat (2) @(posedge clk);
        #1;
        host_cnt   = 12'hF80;
        host_en_d1 = 1'b0;
        rst_n      = 1'b1;

        // Clean lock: ACQUIRE after one edge, TRACK after 1 + 4.
        expect_out("lock_e1", 2'd1, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        run_clean(1, 1'b1);
        check_out();
        expect_out("lock_e4", 2'd1, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        run_clean(3, 1'b1);
        check_out();
        expect_out("lock_e5", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        run_clean(1, 1'b1);
        check_out();

        // Long clean run crossing the 0xFFF -> 0x000 wrap.
        expect_out("clean_300", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        run_clean(300, 1'b1);
        check_out();

        // Single XOR-corrupted sample; the re-anchor makes the next sample bad too.
        expect_out("xor_hit", 2'd2, 1'b1, 16'd1, 12'h0A5, 1'b1, 1'b0);
        cyc(1'b1, 12'h0A5, 12'h000, 1'b0);
        check_out();
        expect_out("xor_after", 2'd2, 1'b1, 16'd2, 12'h0A5, 1'b1, 1'b0);
        run_clean(2, 1'b1);
        check_out();

        // Resync after three consecutive bad samples.
        clear_cycle("clear_pre_resync");
        expect_out("resync_1", 2'd2, 1'b1, 16'd1, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 12'h000, 12'h010, 1'b0);
        check_out();
        cyc(1'b1, 12'h000, 12'h020, 1'b0);
        expect_out("resync_3", 2'd0, 1'b1, 16'd3, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 12'h000, 12'h030, 1'b0);
        check_out();
        expect_out("relock_4", 2'd1, 1'b1, 16'd3, 12'h000, 1'b0, 1'b0);
        run_clean(4, 1'b1);
        check_out();
        expect_out("relock_5", 2'd2, 1'b1, 16'd3, 12'h000, 1'b0, 1'b0);
        run_clean(1, 1'b1);
        check_out();

        // Enable gaps, 3 on / 2 off, with a correctly modelled host.
        clear_cycle("clear_pre_gaps");
        for (int i = 0; i < 30; i++) cyc((i % 5) < 3, 12'h000, 12'h000, 1'b0);
        expect_out("gaps_clean", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        check_out();
        // Count advances while the delayed enable is low.
        run_clean(2, 1'b0);
        expect_out("gap_advance", 2'd2, 1'b1, 16'd1, 12'h000, 1'b0, 1'b0);
        cyc(1'b0, 12'h000, 12'h001, 1'b0);
        check_out();
        run_clean(1, 1'b0);
        expect_out("gap_after", 2'd2, 1'b1, 16'd2, 12'h000, 1'b0, 1'b0);
        run_clean(3, 1'b1);
        check_out();

        // Clear wins over a simultaneous error.
        clear_err = 1'b1;
        expect_out("clear_vs_err", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        cyc(1'b1, 12'h0A5, 12'h000, 1'b0);
        check_out();
        clear_err = 1'b0;
        expect_out("post_clear_err", 2'd2, 1'b1, 16'd1, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 12'h000, 12'h000, 1'b0);
        check_out();
        run_clean(2, 1'b1);

        // Period check: arm, two correct intervals, then one short by one.
        clear_cycle("clear_pre_period");
        cyc(1'b1, 12'h000, 12'h000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            run_clean(99, 1'b1);
            cyc(1'b1, 12'h000, 12'h000, 1'b1);
        end
        expect_out("period_ok", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        check_out();
        run_clean(98, 1'b1);
        expect_out("period_99", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b1);
        cyc(1'b1, 12'h000, 12'h000, 1'b1);
        check_out();
        clear_cycle("clear_period");

        // Missing pulse: saturation at 2*PERIOD enabled cycles.
        run_clean(198, 1'b1);
        expect_out("sat_199", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        check_out();
        expect_out("sat_200", 2'd2, 1'b0, 16'd0, 12'h000, 1'b1, 1'b1);
        run_clean(1, 1'b1);
        check_out();

        // Async reset mid-TRACK with mismatch set.
        expect_out("pre_reset", 2'd2, 1'b1, 16'd1, 12'h0A5, 1'b1, 1'b1);
        cyc(1'b1, 12'h0A5, 12'h000, 1'b0);
        check_out();
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 2'd0, 1'b0, 16'd0, 12'h000, 1'b1, 1'b0);
        check_out();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
